// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial CLA adder: state encoding, nibble width
// and the step-count helper.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int unsigned nibble_steps(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/carry_look_ahead_4bit.sv
// Four-bit carry-look-ahead adder slice: all internal carries are formed
// directly from generate/propagate terms.
module carry_look_ahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

// File: rtl/cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder driving one carry_look_ahead_4bit slice per clock.
// Define CLA_SERIAL_OVF_EN to add the two's-complement overflow output ovf.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int unsigned N     = nibble_steps(WIDTH);
  localparam int unsigned CNT_W = $clog2(N);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [WIDTH-1:0]    a_sh_q, a_sh_d;
  logic [WIDTH-1:0]    b_sh_q, b_sh_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                last_step;

  carry_look_ahead_4bit u_slice (
    .a     (a_sh_q[NIBBLE_W-1:0]),
    .b     (b_sh_q[NIBBLE_W-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  assign last_step = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result nibbles enter at the top so the LSB nibble lands at bit 0 after N steps.
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        sum_d   = {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = carry_q;

`ifdef CLA_SERIAL_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  // The final slice's top sum bit is the result MSB, so overflow resolves on the last step.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if ((state_q == IDLE) && in_valid) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if ((state_q == RUN) && last_step) begin
      ovf_d = (a_msb_q == b_msb_q) && (slice_sum[NIBBLE_W-1] != a_msb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder: directed table, backpressure, mid-run
// reset, back-to-back handshakes and randomized operands against an arithmetic model.
module tb_cla_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef CLA_SERIAL_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  cla_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_SERIAL_OVF_EN
    .ovf       (ovf),
`endif
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           hold;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned and signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    longint unsigned u;
    longint          s;
    logic            o;
    u = longint'(ma) + longint'(mb) + longint'(mc);
    s = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    o = (s > longint'((1 << (W - 1)) - 1)) || (s < -longint'(1 << (W - 1)));
    return {o, u[W], u[W-1:0]};
  endfunction

  // Called at a negedge; leaves the bench at a negedge with the DUT back in IDLE.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input int hold, input logic [W-1:0] es, input logic ec,
                         input logic eo, input string tag);
    int waitc;
    int elapsed;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, {{W{1'b0}}, in_ready}, 1);
      return;
    end
    a = ta; b = tb; c_in = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    chk({tag, "_in_ready_run"}, {{W{1'b0}}, in_ready}, 0);
    elapsed = 0;
    while (!out_valid && elapsed < N + 8) begin
      @(negedge clk);
      elapsed++;
    end
    chk({tag, "_latency"}, (W+1)'(elapsed), (W+1)'(N));
    if (!out_valid) return;
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_sum"}, {1'b0, sum}, {1'b0, es});
      chk({tag, "_c_out"}, {{W{1'b0}}, c_out}, {{W{1'b0}}, ec});
`ifdef CLA_SERIAL_OVF_EN
      chk({tag, "_ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, eo});
`endif
      if (h > 0) begin
        chk({tag, "_hold_valid"}, {{W{1'b0}}, out_valid}, 1);
        chk({tag, "_hold_in_ready"}, {{W{1'b0}}, in_ready}, 0);
      end
      if (h < hold) begin
        in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, {{W{1'b0}}, out_valid}, 0);
    chk({tag, "_release_in_ready"}, {{W{1'b0}}, in_ready}, 1);
    if (eo === 1'bx) $display("note: unknown ovf expectation in %s", tag);
  endtask

  vec_t vecs[8];

  initial begin
    logic [W+1:0]  m;
    logic [W-1:0]  ops_a[3];
    logic [W-1:0]  ops_b[3];
    logic          ops_c[3];
    logic [W+1:0]  expq[$];
    logic [W+1:0]  e;
    int            idx;
    int            got;
    int            seen;
    int            cyc;
    logic          acc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hA5A5, 16'h5A5A, 1'b0, 1, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 5, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 2, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", {{W{1'b0}}, in_ready}, 1);
    chk("reset_out_valid", {{W{1'b0}}, out_valid}, 0);
    chk("reset_sum", {1'b0, sum}, 0);
    chk("reset_c_out", {{W{1'b0}}, c_out}, 0);
`ifdef CLA_SERIAL_OVF_EN
    chk("reset_ovf", {{W{1'b0}}, ovf}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
              vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Reset sampled on the second RUN edge aborts the operation.
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {{W{1'b0}}, in_ready}, 1);
    chk("midrst_out_valid", {{W{1'b0}}, out_valid}, 0);
    chk("midrst_sum", {1'b0, sum}, 0);
    chk("midrst_c_out", {{W{1'b0}}, c_out}, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", (W+1)'(seen), 0);
    run_txn(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, "post_rst");

    // Back-to-back: in_valid stays high across three operand sets.
    ops_a[0] = 16'h0F0F; ops_b[0] = 16'hF0F1; ops_c[0] = 1'b0;
    ops_a[1] = 16'h9999; ops_b[1] = 16'h6667; ops_c[1] = 1'b1;
    ops_a[2] = 16'h4000; ops_b[2] = 16'h4000; ops_c[2] = 1'b0;
    for (int i = 0; i < 3; i++) expq.push_back(model(ops_a[i], ops_b[i], ops_c[i]));
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    a = ops_a[0]; b = ops_b[0]; c_in = ops_c[0]; in_valid = 1'b1;
    while (got < 3 && cyc < 60) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        e = expq.pop_front();
        chk($sformatf("b2b%0d_sum", got), {1'b0, sum}, {1'b0, e[W-1:0]});
        chk($sformatf("b2b%0d_c_out", got), {{W{1'b0}}, c_out}, {{W{1'b0}}, e[W]});
`ifdef CLA_SERIAL_OVF_EN
        chk($sformatf("b2b%0d_ovf", got), {{W{1'b0}}, ovf}, {{W{1'b0}}, e[W+1]});
`endif
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        chk("b2b_ready_after_accept", {{W{1'b0}}, in_ready}, 0);
        idx++;
        if (idx < 3) begin
          a = ops_a[idx]; b = ops_b[idx]; c_in = ops_c[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", (W+1)'(got), 3);
    chk("b2b_accepts", (W+1)'(idx), 3);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      m = model(ra, rb, rc);
      run_txn(ra, rb, rc, int'($urandom_range(0, 2)), m[W-1:0], m[W], m[W+1],
              $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
